mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning number of requesters sharing one shift-add multiplier (2..8).
REQ-002 The block SHALL have parameter W, default 8, meaning operand width; product width is 2*W.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32, meaning watchdog limit in RUN (used only with MULT_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  N_REQ  per-requester request strobe.
REQ-007 req_b  input  N_REQ*W  packed multiplicand operands, requester i at bits [i*W +: W].
REQ-008 req_q  input  N_REQ*W  packed multiplier operands, same packing.
REQ-009 req_ready  output  N_REQ  one-hot accept pulse; transfer when req_valid[i] & req_ready[i].
REQ-010 mul_rst  output  1  active-high restart to the multiplier datapath.
REQ-011 mul_b, mul_q  output  W each  operands driven to the multiplier.
REQ-012 mul_result  input  2*W  multiplier product.
REQ-013 mul_d_end  input  1  multiplier done flag.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_id  output  $clog2(N_REQ)  index of requester owning the response.
REQ-017 rsp_result  output  2*W  registered product.
REQ-018 rsp_err  output  1  response aborted by watchdog.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, RESP.
REQ-021 IDLE: if any req_valid, grant the first set bit at or after rr_ptr (wrapping), assert req_ready[g] that cycle only, capture operands and g, go to LOAD; else stay.
REQ-022 After a grant to g, rr_ptr SHALL become (g+1) mod N_REQ.
REQ-023 LOAD (exactly one cycle): mul_rst=1, mul_b/mul_q = captured operands; go to RUN.
REQ-024 RUN: mul_rst=0, operands held stable; mul_d_end SHALL be ignored in the first RUN cycle; on mul_d_end=1 thereafter, capture mul_result into rsp_result, go to RESP.
REQ-025 RESP: rsp_valid=1, rsp_id/rsp_result/rsp_err stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-026 req_ready SHALL be 0 in LOAD, RUN, RESP; new requests wait, no queueing beyond req_valid held by requester.
REQ-027 A requester deasserting req_valid before acceptance SHALL lose no state; arbitration is re-evaluated every IDLE cycle.
REQ-028 Minimum latency accept-to-rsp_valid SHALL be 2 cycles plus multiplier run time; one response outstanding at most.
REQ-029 mul_b, mul_q SHALL hold last captured values in IDLE and RESP; mul_rst=1 in IDLE and RESP.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, mul_rst=1, mul_b=0, mul_q=0.
REQ-031 Reset mid-operation (LOAD/RUN/RESP) SHALL discard the transaction with no response issued.

Configuration
REQ-032 With MULT_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to RUN; if TIMEOUT_CYCLES RUN cycles elapse without mul_d_end, go to RESP with rsp_err=1, rsp_result=0.
REQ-033 Without MULT_ARB_TIMEOUT_EN, no counter exists, RUN waits indefinitely, rsp_err is tied 0.

Verification
REQ-034 Single request: req_valid=0001, b=127, q=201 -> rsp_valid with rsp_id=0, rsp_result=25527, rsp_err=0.
REQ-035 Round-robin: req_valid=1111 held, operands i*10+1 x 2 -> rsp_id order 0,1,2,3,0; results 2,22,42,62,2.
REQ-036 Max operands: requester 3, b=255, q=255 -> rsp_result=65025; rsp held while rsp_ready=0 for 5 cycles, then released.
REQ-037 Reset mid-RUN: rst=0 one cycle during RUN -> no rsp_valid, busy=0, next grant from requester 0.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=32): mul_d_end stuck 0 -> rsp_valid after 32 RUN cycles, rsp_err=1, rsp_result=0.
REQ-039 Stale done: mul_d_end=1 during LOAD and first RUN cycle -> not accepted; response only on later mul_d_end.

Source files
------------

// File: rtl/mult_arbiter.sv
// Purpose : round-robin arbiter sharing one external shift-add multiplier among N_REQ requesters.
// Latency : accept -> rsp_valid = 2 cycles (LOAD + first RUN) plus multiplier run time; one transaction in flight.
// Backpr. : req_ready is low while busy; the response is held until rsp_ready, and requesters hold req_valid to wait.
//
// Ports   : clk, rst (sync, active-low)
//           req_valid/req_b/req_q/req_ready  packed requester interface, requester i at [i*W +: W]
//           mul_rst/mul_b/mul_q/mul_result/mul_d_end  multiplier datapath handshake
//           rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_err  response channel
//           busy  high whenever the FSM is not in IDLE
// Option  : define MULT_ARB_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYCLES cycles (rsp_err=1 on expiry).
module mult_arbiter #(
  parameter int N_REQ          = 4,
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W-1:0]         req_b,
  input  logic [N_REQ*W-1:0]         req_q,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       mul_rst,
  output logic [W-1:0]               mul_b,
  output logic [W-1:0]               mul_q,
  input  logic [2*W-1:0]             mul_result,
  input  logic                       mul_d_end,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*W-1:0]             rsp_result,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;
  logic           accept;
  logic           run_first;
  logic           done_take;
  logic           timeout_hit;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_v = idx[IDW-1:0];
      if (!grant_any && req_valid[idx_v]) begin
        grant_any = 1'b1;
        grant_idx = idx_v;
      end
    end
  end

  // Gated with rst so nothing looks accepted while reset is being applied.
  assign accept    = (state == IDLE) && grant_any && rst;
  assign req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

  // mul_d_end in the first RUN cycle may be left over from the previous job.
  assign done_take = (state == RUN) && !run_first && mul_d_end;

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign mul_rst   = (state != RUN);

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] run_cnt;
  logic          err_q;

  // run_cnt is 0 in the first RUN cycle, so expiry lands on the TIMEOUT_CYCLES-th RUN cycle.
  assign timeout_hit = (state == RUN) && !done_take && (run_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 1'b1;
      if (accept)            err_q <= 1'b0;
      else if (timeout_hit)  err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (done_take || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      mul_b      <= '0;
      mul_q      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      run_first  <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_first <= (state == LOAD);
      if (accept) begin
        mul_b  <= req_b[grant_idx*W +: W];
        mul_q  <= req_q[grant_idx*W +: W];
        rsp_id <= grant_idx;
        rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
      if (done_take)        rsp_result <= mul_result;
      else if (timeout_hit) rsp_result <= '0;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_b, req_q;
  logic [N-1:0]   req_ready;
  logic           mul_rst;
  logic [W-1:0]   mul_b, mul_q;
  logic [2*W-1:0] mul_result;
  logic           mul_d_end;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [2*W-1:0] rsp_result;
  logic           rsp_err;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_b(req_b), .req_q(req_q), .req_ready(req_ready),
    .mul_rst(mul_rst), .mul_b(mul_b), .mul_q(mul_q),
    .mul_result(mul_result), .mul_d_end(mul_d_end),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
    bit          stale;
    int          hold;
    int          id;
    int          res;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one transaction through a behavioural multiplier that finishes on RUN cycle 'lat'
  // (lat=0: never finishes). With 'stale', mul_d_end is also pulsed in LOAD and RUN cycle 1
  // while mul_result carries a poison value.
  task automatic run_txn(input string nm, input int lat, input bit stale, input int hold,
                         input int exp_id, input int exp_res, input bit exp_err, input int exp_run);
    int         cyc, run_cnt, acc;
    bit         got, ready_bad, hold_ok;
    logic [3:0] exp_rdy;
    cyc = 0; run_cnt = 0; acc = -1; got = 0; ready_bad = 0;
    exp_rdy = 4'b0001 << exp_id;
    #1;
    while (!got && cyc < 300) begin
      if (req_ready != 0) begin
        if (acc < 0 && !busy) begin
          acc = cyc;
          check({nm, "_grant"}, req_ready, exp_rdy);
        end else ready_bad = 1;
      end
      if (!mul_rst) run_cnt++;
      if (mul_rst)           mul_d_end = stale && busy && !rsp_valid;
      else if (run_cnt == 1) mul_d_end = stale;
      else                   mul_d_end = (lat > 0) && (run_cnt >= lat);
      mul_result = (lat > 0 && run_cnt >= lat) ? ({8'd0, mul_b} * {8'd0, mul_q}) : 16'hDEAD;
      if (rsp_valid) got = 1;
      else begin
        step();
        cyc++;
      end
    end
    mul_d_end = 1'b0;
    check({nm, "_accepted"}, acc >= 0, 1);
    check({nm, "_rsp_seen"}, got, 1);
    check({nm, "_latency"}, cyc - acc, 2 + exp_run);
    check({nm, "_rsp_id"}, rsp_id, exp_id);
    check({nm, "_rsp_result"}, rsp_result, exp_res);
    check({nm, "_rsp_err"}, rsp_err, exp_err);
    check({nm, "_no_ready_busy"}, ready_bad, 0);
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      hold_ok = rsp_valid && (rsp_id == exp_id) && (rsp_result == exp_res) && (rsp_err == exp_err);
      check({nm, "_rsp_hold"}, hold_ok, 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({nm, "_release"}, {rsp_valid, busy}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit seen;
    // Round-robin: operands i*10+1 x 2
    tbl[0] = '{4'b1111, 32'h1F15_0B01, 32'h0202_0202, 3, 0, 0, 0, 2};
    tbl[1] = '{4'b1111, 32'h1F15_0B01, 32'h0202_0202, 2, 0, 0, 1, 22};
    tbl[2] = '{4'b1111, 32'h1F15_0B01, 32'h0202_0202, 4, 0, 0, 2, 42};
    tbl[3] = '{4'b1111, 32'h1F15_0B01, 32'h0202_0202, 2, 0, 0, 3, 62};
    tbl[4] = '{4'b1111, 32'h1F15_0B01, 32'h0202_0202, 3, 0, 0, 0, 2};
    // Single request 127 x 201
    tbl[5] = '{4'b0001, 32'h0000_007F, 32'h0000_00C9, 3, 0, 1, 0, 25527};
    // Max operands on requester 3, response stalled 5 cycles
    tbl[6] = '{4'b1000, 32'hFF00_0000, 32'hFF00_0000, 5, 0, 5, 3, 65025};
    // Stale done in LOAD and first RUN cycle, 13 x 11
    tbl[7] = '{4'b0100, 32'h000D_0000, 32'h000B_0000, 4, 1, 0, 2, 143};
    // Pointer at 3: wraps to requester 0 (5 x 7)
    tbl[8] = '{4'b0011, 32'h0000_0305, 32'h0000_0707, 2, 0, 0, 0, 35};
    // Pointer at 1: requester 1 (6 x 5)
    tbl[9] = '{4'b0110, 32'h0004_0600, 32'h0002_0500, 3, 0, 0, 1, 30};

    rst = 1'b0; req_valid = '0; req_b = '0; req_q = '0;
    mul_result = '0; mul_d_end = 1'b0; rsp_ready = 1'b0;
    step(); step();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_rst", mul_rst, 1);
    check("rst_mul_ops", {mul_b, mul_q}, 0);
    check("rst_rsp_fields", {rsp_id, rsp_result, rsp_err}, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].rv;
      req_b     = tbl[i].b;
      req_q     = tbl[i].q;
      run_txn($sformatf("vec%0d", i), tbl[i].lat, tbl[i].stale, tbl[i].hold,
              tbl[i].id, tbl[i].res, 1'b0, tbl[i].lat);
    end
    req_valid = '0;
    step();

    // Reset in the middle of RUN: transaction dropped, pointer back to 0.
    req_valid = 4'b0001; req_b = 32'h0000_0003; req_q = 32'h0000_0009;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (!mul_rst) seen = 1;
    end
    check("midrun_reached_run", seen, 1);
    step();
    rst = 1'b0;
    step();
    check("midrun_busy", busy, 0);
    check("midrun_rsp_valid", rsp_valid, 0);
    check("midrun_req_ready", req_ready, 0);
    check("midrun_mul_state", {mul_rst, mul_b, mul_q}, {1'b1, 16'h0000});
    check("midrun_rsp_fields", {rsp_id, rsp_result, rsp_err}, 0);
    req_valid = '0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid || busy) seen = 1;
    end
    check("midrun_no_response", seen, 0);
    req_valid = 4'b1111; req_b = 32'h0506_0708; req_q = 32'h0102_0304;
    run_txn("post_reset", 3, 0, 0, 0, 32, 1'b0, 3);
    req_valid = '0;
    step();

`ifdef MULT_ARB_TIMEOUT_EN
    req_valid = 4'b0010; req_b = 32'h0000_0A00; req_q = 32'h0000_0B00;
    run_txn("timeout", 0, 0, 2, 1, 0, 1'b1, 32);
    req_valid = '0;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
